// File: rtl/zflag_gen.sv
// -----------------------------------------------------------------------------
// zflag_gen -- zero-flag generator for the CPU datapath (producer end of the
// Z flag interface).
//
// Accepts ALU result words over a valid/ready handshake, holds them for one
// stage (S1), then folds each word into a zero condition. Results wider than
// the datapath arrive as chains of words terminated by res_last. When a chain
// (or a single-word result) completes, a one-cycle flag_we pulse is issued
// together with the new z_out value.
//
// Optional feature (macro ZFLAG_NEG_EN): adds n_out, the sign flag, taken
// from the MSB of the final word of each chain and updated with flag_we.
//
// Ports:
//   clk        in   single clock, rising edge
//   clear      in   synchronous active-high reset
//   res_in     in   ALU result word [WIDTH-1:0]
//   res_valid  in   res_in valid this cycle
//   res_last   in   final (or only) word of a result
//   res_ready  out  word accepted this cycle (combinational)
//   flag_hold  in   pipeline stall, freezes S1 and the FSM
//   flag_we    out  one-cycle Z register load pulse
//   z_out      out  zero flag value, held between updates
//   n_out      out  sign flag (ZFLAG_NEG_EN only)
// -----------------------------------------------------------------------------
module zflag_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] res_in,
   input  logic             res_valid,
   input  logic             res_last,
   output logic             res_ready,
   input  logic             flag_hold,
   output logic             flag_we,
   output logic             z_out
`ifdef ZFLAG_NEG_EN
   ,
   output logic             n_out
`endif
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Stage 1 holding register
   logic [WIDTH-1:0] s1_word_reg;
   logic             s1_last_reg;
   logic             s1_valid_reg;

   // FSM and flag state
   state_t state_reg, state_next;
   logic   acc_zero_reg, acc_zero_next;
   logic   flag_we_reg, flag_we_next;
   logic   z_reg, z_next;
`ifdef ZFLAG_NEG_EN
   logic   n_reg, n_next;
`endif

   logic advance;
   logic accept;
   logic wz;

   // OR chain across the S1 word; the word is zero when no bit is set.
   logic [WIDTH:0] or_chain;
   assign or_chain[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_chain
         assign or_chain[gi+1] = or_chain[gi] | s1_word_reg[gi];
      end
   endgenerate

   assign wz = ~or_chain[WIDTH];

   // A stalled, occupied S1 cannot take a new word; an empty S1 still can.
   assign res_ready = !clear && !(flag_hold && s1_valid_reg);
   assign accept    = res_valid && res_ready;
   assign advance   = s1_valid_reg && !flag_hold;

   // S1: loading a new word takes priority over draining, which gives full
   // throughput when a word advances and another arrives in the same cycle.
   always_ff @(posedge clk) begin
      if (clear) begin
         s1_valid_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_word_reg  <= '0;
      end else if (accept) begin
         s1_valid_reg <= 1'b1;
         s1_last_reg  <= res_last;
         s1_word_reg  <= res_in;
      end else if (advance) begin
         s1_valid_reg <= 1'b0;
      end
   end

   // FSM next-state and flag computation
   always_comb begin
      state_next    = state_reg;
      acc_zero_next = acc_zero_reg;
      flag_we_next  = 1'b0;
      z_next        = z_reg;
`ifdef ZFLAG_NEG_EN
      n_next        = n_reg;
`endif
      if (advance) begin
         case (state_reg)
            IDLE: begin
               if (s1_last_reg) begin
                  z_next       = wz;
                  flag_we_next = 1'b1;
`ifdef ZFLAG_NEG_EN
                  n_next       = s1_word_reg[WIDTH-1];
`endif
               end else begin
                  acc_zero_next = wz;
                  state_next    = ACCUM;
               end
            end
            ACCUM: begin
               if (s1_last_reg) begin
                  z_next       = acc_zero_reg & wz;
                  flag_we_next = 1'b1;
                  state_next   = IDLE;
`ifdef ZFLAG_NEG_EN
                  n_next       = s1_word_reg[WIDTH-1];
`endif
               end else begin
                  acc_zero_next = acc_zero_reg & wz;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_reg    <= IDLE;
         acc_zero_reg <= 1'b0;
         flag_we_reg  <= 1'b0;
         z_reg        <= 1'b0;
`ifdef ZFLAG_NEG_EN
         n_reg        <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         acc_zero_reg <= acc_zero_next;
         flag_we_reg  <= flag_we_next;
         z_reg        <= z_next;
`ifdef ZFLAG_NEG_EN
         n_reg        <= n_next;
`endif
      end
   end

   assign flag_we = flag_we_reg;
   assign z_out   = z_reg;
`ifdef ZFLAG_NEG_EN
   assign n_out   = n_reg;
`endif

endmodule

// File: tb/tb_zflag_gen.sv
// -----------------------------------------------------------------------------
// tb_zflag_gen -- self-checking bench for zflag_gen (WIDTH=8).
// Directed scenarios compare against fixed expected values; the random test
// compares against a queue-based reference model of the handshake and chains.
// -----------------------------------------------------------------------------
module tb_zflag_gen;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [7:0] res_in = 8'h00;
   logic       res_valid = 1'b0;
   logic       res_last = 1'b0;
   logic       res_ready;
   logic       flag_hold = 1'b0;
   logic       flag_we;
   logic       z_out;
`ifdef ZFLAG_NEG_EN
   logic       n_out;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   zflag_gen #(.WIDTH(8)) dut (
      .clk       (clk),
      .clear     (clear),
      .res_in    (res_in),
      .res_valid (res_valid),
      .res_last  (res_last),
      .res_ready (res_ready),
      .flag_hold (flag_hold),
      .flag_we   (flag_we),
      .z_out     (z_out)
`ifdef ZFLAG_NEG_EN
      ,
      .n_out     (n_out)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] w;
      logic       l;
   } word_t;

   word_t      m_s1[$];     // the one-entry stage buffer
   logic [7:0] m_chain[$];  // words of the chain in progress
   logic       m_we = 1'b0;
   logic       m_z  = 1'b0;
   logic       m_n  = 1'b0;
   logic       exp_ready;
   logic       obs_ready;

   // Drive one cycle of inputs, sample res_ready before the edge, update the
   // model for that edge, then return 1 time unit after the edge.
   task automatic tick(input logic c, input logic v, input logic l,
                       input logic [7:0] d, input logic h);
      word_t e;
      clear     = c;
      res_valid = v;
      res_last  = l;
      res_in    = d;
      flag_hold = h;
      #1;
      obs_ready = res_ready;
      exp_ready = !c && !(h && (m_s1.size() != 0));
      if (c) begin
         m_s1.delete();
         m_chain.delete();
         m_we = 1'b0;
         m_z  = 1'b0;
         m_n  = 1'b0;
      end else begin
         m_we = 1'b0;
         if (m_s1.size() != 0 && !h) begin
            e = m_s1.pop_front();
            m_chain.push_back(e.w);
            if (e.l) begin
               m_z = 1'b1;
               foreach (m_chain[i]) if (m_chain[i] != 8'h00) m_z = 1'b0;
               m_n  = e.w[7];
               m_we = 1'b1;
               m_chain.delete();
            end
         end
         if (v && exp_ready) begin
            e.w = d;
            e.l = l;
            m_s1.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
         checks++;
         if (obs_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", obs_ready);
         end
         checks++;
         if (flag_we !== 1'b0 || z_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got we=%b z=%b expected we=0 z=0", flag_we, z_out);
         end
      end
      idle();
      checks++;
      if (obs_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_after: got %b expected 1", obs_ready);
      end
      idle();
      idle();
      checks++;
      if (flag_we !== 1'b0 || z_out !== 1'b0) begin
         errors++; $display("FAIL reset_no_accept: got we=%b z=%b expected we=0 z=0", flag_we, z_out);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_words();
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      checks++;
      if (obs_ready !== 1'b1 || flag_we !== 1'b0) begin
         errors++; $display("FAIL single_first: got ready=%b we=%b expected ready=1 we=0", obs_ready, flag_we);
      end
      tick(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
      checks++;
      if (flag_we !== 1'b1 || z_out !== 1'b1) begin
         errors++; $display("FAIL single_pulse1: got we=%b z=%b expected we=1 z=1", flag_we, z_out);
      end
      idle();
      checks++;
      if (flag_we !== 1'b1 || z_out !== 1'b0) begin
         errors++; $display("FAIL single_pulse2: got we=%b z=%b expected we=1 z=0", flag_we, z_out);
      end
      idle();
      checks++;
      if (flag_we !== 1'b0 || z_out !== 1'b0) begin
         errors++; $display("FAIL single_after: got we=%b z=%b expected we=0 z=0", flag_we, z_out);
      end
      $display("test_single_words done");
   endtask

   task automatic test_chain();
      int   pulses;
      logic zv;
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      pulses = 0; zv = 1'bx;
      for (int i = 0; i < 4; i++) begin
         idle();
         if (flag_we === 1'b1) begin pulses++; zv = z_out; end
      end
      checks++;
      if (pulses != 1 || zv !== 1'b1) begin
         errors++; $display("FAIL chain_zero: got pulses=%0d z=%b expected pulses=1 z=1", pulses, zv);
      end
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle();  // gap between chain words is legal
      tick(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
      checks++;
      if (flag_we !== 1'b0) begin
         errors++; $display("FAIL chain_mid_pulse: got we=%b expected 0", flag_we);
      end
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      pulses = 0; zv = 1'bx;
      for (int i = 0; i < 4; i++) begin
         idle();
         if (flag_we === 1'b1) begin pulses++; zv = z_out; end
      end
      checks++;
      if (pulses != 1 || zv !== 1'b0) begin
         errors++; $display("FAIL chain_nonzero: got pulses=%0d z=%b expected pulses=1 z=0", pulses, zv);
      end
      $display("test_chain done");
   endtask

   task automatic test_stall();
      int pulses;
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
         checks++;
         if (obs_ready !== 1'b0 || flag_we !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: got ready=%b we=%b expected ready=0 we=0", i, obs_ready, flag_we);
         end
      end
      tick(1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
      checks++;
      if (obs_ready !== 1'b1 || flag_we !== 1'b1 || z_out !== 1'b1) begin
         errors++; $display("FAIL stall_release1: got ready=%b we=%b z=%b expected ready=1 we=1 z=1", obs_ready, flag_we, z_out);
      end
      idle();
      checks++;
      if (flag_we !== 1'b1 || z_out !== 1'b0) begin
         errors++; $display("FAIL stall_release2: got we=%b z=%b expected we=1 z=0", flag_we, z_out);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         idle();
         if (flag_we === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL stall_duplicate: got extra pulses=%0d expected 0", pulses);
      end
      $display("test_stall done");
   endtask

   task automatic test_clear_mid_chain();
      int   pulses;
      logic zv;
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);  // set z_out to 1 first
      idle();
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle();                                 // chain word now in ACCUM
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (flag_we !== 1'b0 || z_out !== 1'b0) begin
         errors++; $display("FAIL clear_mid: got we=%b z=%b expected we=0 z=0", flag_we, z_out);
      end
      tick(1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
      pulses = 0; zv = 1'bx;
      for (int i = 0; i < 4; i++) begin
         idle();
         if (flag_we === 1'b1) begin pulses++; zv = z_out; end
      end
      checks++;
      if (pulses != 1 || zv !== 1'b0) begin
         errors++; $display("FAIL clear_after: got pulses=%0d z=%b expected pulses=1 z=0", pulses, zv);
      end
      $display("test_clear_mid_chain done");
   endtask

`ifdef ZFLAG_NEG_EN
   task automatic test_neg();
      tick(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
      idle();
      checks++;
      if (flag_we !== 1'b1 || z_out !== 1'b0 || n_out !== 1'b1) begin
         errors++; $display("FAIL neg_80: got we=%b z=%b n=%b expected we=1 z=0 n=1", flag_we, z_out, n_out);
      end
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      idle();
      checks++;
      if (flag_we !== 1'b1 || z_out !== 1'b1 || n_out !== 1'b0) begin
         errors++; $display("FAIL neg_00: got we=%b z=%b n=%b expected we=1 z=1 n=0", flag_we, z_out, n_out);
      end
      $display("test_neg done");
   endtask
`endif

   task automatic test_random();
      logic       c, v, l, h;
      logic [7:0] d;
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(0, 99) < 3);
         v = ($urandom_range(0, 9) < 6);
         l = ($urandom_range(0, 9) < 4);
         h = ($urandom_range(0, 9) < 3);
         d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         tick(c, v, l, d, h);
         checks++;
         if (obs_ready !== exp_ready) begin
            errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", i, obs_ready, exp_ready);
         end
         checks++;
         if (flag_we !== m_we || z_out !== m_z) begin
            errors++; $display("FAIL rand_flags cyc%0d: got we=%b z=%b expected we=%b z=%b", i, flag_we, z_out, m_we, m_z);
         end
`ifdef ZFLAG_NEG_EN
         checks++;
         if (n_out !== m_n) begin
            errors++; $display("FAIL rand_neg cyc%0d: got %b expected %b", i, n_out, m_n);
         end
`endif
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_single_words();
      test_chain();
      test_stall();
      test_clear_mid_chain();
`ifdef ZFLAG_NEG_EN
      test_neg();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
